mc_ctrl_fsm: RTL and testbench

// Multi-cycle control unit for the MIPS-subset multicycle datapath. Decodes opcode/funct,

---
 rtl/mc_ctrl_fsm.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle control unit for the MIPS-subset multicycle datapath. It decodes
// opcode/funct, steps each instruction through IF/ID/EX/MEM/WB and drives every
// datapath select.
//
// Build option: define MCCTRL_MEM_WAIT_EN to make IF, MR and MW wait for
// mem_ready, with a WAIT_MAX-cycle timeout that raises bus_err. With the macro
// undefined, memory is single-cycle, mem_ready is ignored and bus_err is 0.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   opcode/funct IR[31:26] / IR[5:0]; read only in ID, RX and IX
//   zero         ALU zero flag, used only in BR
//   mem_ready    memory access done (used only with MCCTRL_MEM_WAIT_EN)
//   pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b, imm_zext, alu_ctrl, pc_source
//                datapath controls (encodings are listed at the localparams)
//   illegal      1-cycle pulse in ID for an unsupported opcode/funct
//   bus_err      1-cycle pulse after a memory wait timeout
//   state        current state code, for debug
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
   parameter int WAIT_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       imm_zext,
   output logic [2:0] alu_ctrl,
   output logic [1:0] pc_source,
   output logic       illegal,
   output logic       bus_err,
   output logic [4:0] state
);

   typedef enum logic [4:0] {
      S_RST = 5'd0,  S_IF  = 5'd1,  S_ID  = 5'd2,  S_MA  = 5'd3,
      S_MR  = 5'd4,  S_MWB = 5'd5,  S_MW  = 5'd6,  S_RX  = 5'd7,
      S_RWB = 5'd8,  S_IX  = 5'd9,  S_IWB = 5'd10, S_BR  = 5'd11,
      S_J   = 5'd12, S_JR  = 5'd13, S_JAL = 5'd14, S_LUI = 5'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                          OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                          OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

   localparam logic [5:0] F_JR  = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22,
                          F_AND = 6'h24, F_OR  = 6'h25, F_NOR = 6'h27,
                          F_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                          ALU_SUB = 3'b110, ALU_SLT = 3'b111, ALU_NOR = 3'b100;

   state_t cur, nxt, id_nxt;
   logic   id_legal;
   logic   is_sw_q, is_bne_q;
   logic   fetch_ok;

   // Registered copies of the Moore outputs; they are loaded from the decode of
   // the next state so they change together with 'state'.
   logic       pc_write_q, i_or_d_q, mem_read_q, mem_write_q, ir_write_q;
   logic [1:0] reg_dst_q, mem_to_reg_q, alu_src_b_q, pc_source_q;
   logic       reg_write_q, alu_src_a_q, imm_zext_q;
   logic [2:0] alu_ctrl_q;

   logic       pc_write_d, i_or_d_d, mem_read_d, mem_write_d, ir_write_d;
   logic [1:0] reg_dst_d, mem_to_reg_d, alu_src_b_d, pc_source_d;
   logic       reg_write_d, alu_src_a_d, imm_zext_d;
   logic [2:0] alu_ctrl_d;

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         F_SUB:   return ALU_SUB;
         F_AND:   return ALU_AND;
         F_OR:    return ALU_OR;
         F_NOR:   return ALU_NOR;
         F_SLT:   return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic [2:0] imm_alu(input logic [5:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_SLTI: return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   // ID dispatch and legality check
   always_comb begin
      id_nxt   = S_IF;
      id_legal = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_JR:                                 id_nxt = S_JR;
               F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: id_nxt = S_RX;
               default:                              id_legal = 1'b0;
            endcase
         end
         OP_LW, OP_SW:                     id_nxt = S_MA;
         OP_BEQ, OP_BNE:                   id_nxt = S_BR;
         OP_J:                             id_nxt = S_J;
         OP_JAL:                           id_nxt = S_JAL;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: id_nxt = S_IX;
         OP_LUI:                           id_nxt = S_LUI;
         default:                          id_legal = 1'b0;
      endcase
   end

`ifdef MCCTRL_MEM_WAIT_EN
   // mem_ready handshake: a memory state (IF, MR, MW) presents its strobes and
   // holds them every cycle until mem_ready=1; the access completes on that
   // cycle and the FSM advances on the following edge.
   logic [4:0] wait_cnt;
   logic       bus_err_q;
   logic       hold_state, stall, timeout;

   assign hold_state = (cur == S_IF) || (cur == S_MR) || (cur == S_MW);
   assign stall      = hold_state && !mem_ready;
   assign timeout    = stall && (wait_cnt == 5'(WAIT_MAX - 1));
   // PC/IR load only on the cycle the fetch completes
   assign fetch_ok   = (cur != S_IF) || mem_ready;
   assign bus_err    = bus_err_q;
`else
   logic unused_cfg;
   assign unused_cfg = mem_ready ^ (WAIT_MAX < 0);
   assign fetch_ok   = 1'b1;
   assign bus_err    = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      case (cur)
         S_RST:   nxt = S_IF;
         S_IF:    nxt = S_ID;
         S_ID:    nxt = id_nxt;
         S_MA:    nxt = is_sw_q ? S_MW : S_MR;
         S_MR:    nxt = S_MWB;
         S_RX:    nxt = S_RWB;
         S_IX:    nxt = S_IWB;
         default: nxt = S_IF;
      endcase
`ifdef MCCTRL_MEM_WAIT_EN
      // timeout abandons the access; the skipped write-back states mean no
      // register update happens
      if (stall) nxt = timeout ? S_IF : cur;
`endif
   end

   // Output decode for the state about to be entered
   always_comb begin
      pc_write_d   = 1'b0;
      i_or_d_d     = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      ir_write_d   = 1'b0;
      reg_dst_d    = 2'b00;
      mem_to_reg_d = 2'b00;
      reg_write_d  = 1'b0;
      alu_src_a_d  = 1'b0;
      alu_src_b_d  = 2'b00;
      imm_zext_d   = 1'b0;
      alu_ctrl_d   = ALU_AND;
      pc_source_d  = 2'b00;
      case (nxt)
         S_IF: begin
            mem_read_d  = 1'b1;
            ir_write_d  = 1'b1;
            alu_src_b_d = 2'b01;
            alu_ctrl_d  = ALU_ADD;
            pc_write_d  = 1'b1;
         end
         S_ID: begin
            alu_src_b_d = 2'b11;
            alu_ctrl_d  = ALU_ADD;
         end
         S_MA: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'b10;
            alu_ctrl_d  = ALU_ADD;
         end
         S_MR: begin
            i_or_d_d   = 1'b1;
            mem_read_d = 1'b1;
         end
         S_MWB: begin
            mem_to_reg_d = 2'b01;
            reg_write_d  = 1'b1;
         end
         S_MW: begin
            i_or_d_d    = 1'b1;
            mem_write_d = 1'b1;
         end
         // entered from ID, where IR is stable, so funct/opcode are valid here
         S_RX: begin
            alu_src_a_d = 1'b1;
            alu_ctrl_d  = funct_alu(funct);
         end
         S_RWB: begin
            reg_dst_d   = 2'b01;
            reg_write_d = 1'b1;
         end
         S_IX: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'b10;
            imm_zext_d  = (opcode == OP_ANDI) || (opcode == OP_ORI);
            alu_ctrl_d  = imm_alu(opcode);
         end
         S_IWB: reg_write_d = 1'b1;
         // pc_write in BR comes from the live zero flag at the port
         S_BR: begin
            alu_src_a_d = 1'b1;
            alu_ctrl_d  = ALU_SUB;
            pc_source_d = 2'b01;
         end
         S_J: begin
            pc_source_d = 2'b10;
            pc_write_d  = 1'b1;
         end
         S_JR: begin
            pc_source_d = 2'b11;
            pc_write_d  = 1'b1;
         end
         S_JAL: begin
            reg_dst_d    = 2'b10;
            mem_to_reg_d = 2'b10;
            reg_write_d  = 1'b1;
            pc_source_d  = 2'b10;
            pc_write_d   = 1'b1;
         end
         S_LUI: begin
            mem_to_reg_d = 2'b11;
            reg_write_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur          <= S_RST;
         is_sw_q      <= 1'b0;
         is_bne_q     <= 1'b0;
         pc_write_q   <= 1'b0;
         i_or_d_q     <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         ir_write_q   <= 1'b0;
         reg_dst_q    <= 2'b00;
         mem_to_reg_q <= 2'b00;
         reg_write_q  <= 1'b0;
         alu_src_a_q  <= 1'b0;
         alu_src_b_q  <= 2'b00;
         imm_zext_q   <= 1'b0;
         alu_ctrl_q   <= 3'b000;
         pc_source_q  <= 2'b00;
`ifdef MCCTRL_MEM_WAIT_EN
         wait_cnt     <= 5'd0;
         bus_err_q    <= 1'b0;
`endif
      end else begin
         cur          <= nxt;
         pc_write_q   <= pc_write_d;
         i_or_d_q     <= i_or_d_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         ir_write_q   <= ir_write_d;
         reg_dst_q    <= reg_dst_d;
         mem_to_reg_q <= mem_to_reg_d;
         reg_write_q  <= reg_write_d;
         alu_src_a_q  <= alu_src_a_d;
         alu_src_b_q  <= alu_src_b_d;
         imm_zext_q   <= imm_zext_d;
         alu_ctrl_q   <= alu_ctrl_d;
         pc_source_q  <= pc_source_d;
         // opcode is captured in ID so MA and BR never look at IR again
         if (cur == S_ID) begin
            is_sw_q  <= (opcode == OP_SW);
            is_bne_q <= (opcode == OP_BNE);
         end
`ifdef MCCTRL_MEM_WAIT_EN
         if ((nxt != cur) || timeout) wait_cnt <= 5'd0;
         else if (stall)              wait_cnt <= wait_cnt + 5'd1;
         bus_err_q <= timeout;
`endif
      end
   end

   assign pc_write   = (cur == S_BR) ? (is_bne_q ? ~zero : zero) : (pc_write_q & fetch_ok);
   assign ir_write   = ir_write_q & fetch_ok;
   assign i_or_d     = i_or_d_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign reg_dst    = reg_dst_q;
   assign mem_to_reg = mem_to_reg_q;
   assign reg_write  = reg_write_q;
   assign alu_src_a  = alu_src_a_q;
   assign alu_src_b  = alu_src_b_q;
   assign imm_zext   = imm_zext_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign pc_source  = pc_source_q;
   assign illegal    = (cur == S_ID) && !id_legal;
   assign state      = cur;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm: a table of instruction records (opcode,
// funct, zero, expected state path, expected output bundle at one chosen
// cycle), followed by hand-written sequences for reset, illegal decode, IR
// sampling and (when MCCTRL_MEM_WAIT_EN is defined) memory waits.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
   logic       reg_write, alu_src_a, imm_zext, illegal, bus_err;
   logic [2:0] alu_ctrl;
   logic [4:0] state;

   mc_ctrl_fsm #(.WAIT_MAX(16)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
      .alu_ctrl(alu_ctrl), .pc_source(pc_source), .illegal(illegal),
      .bus_err(bus_err), .state(state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   localparam logic [4:0] ST_RST = 5'd0, ST_IF = 5'd1, ST_ID = 5'd2, ST_MA = 5'd3,
                          ST_MR = 5'd4, ST_MWB = 5'd5, ST_MW = 5'd6, ST_RX = 5'd7,
                          ST_RWB = 5'd8, ST_IX = 5'd9, ST_IWB = 5'd10, ST_BR = 5'd11,
                          ST_J = 5'd12, ST_JR = 5'd13, ST_JAL = 5'd14, ST_LUI = 5'd15;

   // observed output bundle, same field order as eb()
   logic [20:0] obs;
   assign obs = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, imm_zext, alu_ctrl, pc_source,
                 illegal, bus_err};

   function automatic logic [20:0] eb(
      input logic pcw, input logic iord, input logic mr, input logic mw, input logic irw,
      input logic [1:0] rd, input logic [1:0] m2r, input logic rw, input logic a,
      input logic [1:0] b, input logic zx, input logic [2:0] alu, input logic [1:0] pcs,
      input logic ill);
      return {pcw, iord, mr, mw, irw, rd, m2r, rw, a, b, zx, alu, pcs, ill, 1'b0};
   endfunction

   function automatic logic [24:0] pth(input logic [4:0] s0, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] s3,
                                       input logic [4:0] s4);
      return {s4, s3, s2, s1, s0};
   endfunction

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      int          ncyc;
      logic [24:0] path;
      int          chk;
      logic [20:0] exp_bus;
   } vec_t;

   vec_t vecs[32];
   int   nvec = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int ncyc, input logic [24:0] path, input int chk,
                          input logic [20:0] exp_bus);
      vecs[nvec].op      = op;
      vecs[nvec].fn      = fn;
      vecs[nvec].z       = z;
      vecs[nvec].ncyc    = ncyc;
      vecs[nvec].path    = path;
      vecs[nvec].chk     = chk;
      vecs[nvec].exp_bus = exp_bus;
      nvec++;
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d] t=%0t: got %h expected %h", name, idx, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // apply one table record starting from an IF cycle
   task automatic run_vec(input int v);
      opcode = vecs[v].op;
      funct  = vecs[v].fn;
      zero   = vecs[v].z;
      for (int c = 0; c < vecs[v].ncyc; c++) begin
         check("state_path", v, {27'd0, state}, {27'd0, vecs[v].path[c*5 +: 5]});
         if (c == vecs[v].chk) check("outputs", v, {11'd0, obs}, {11'd0, vecs[v].exp_bus});
         check("rw_mw_or_rd11", v, {30'd0, mem_write & reg_write, reg_dst == 2'b11}, 32'd0);
         step();
      end
      check("back_to_if", v, {27'd0, state}, {27'd0, ST_IF});
   endtask

   logic [20:0] b_if, b_id, b_zero;

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'h00;
      funct     = 6'h20;
      zero      = 1'b0;
      mem_ready = 1'b1;
      b_if   = eb(1,0,1,0,1,2'b00,2'b00,0,0,2'b01,0,3'b010,2'b00,0);
      b_id   = eb(0,0,0,0,0,2'b00,2'b00,0,0,2'b11,0,3'b010,2'b00,0);
      b_zero = 21'd0;

      // R-type: IF ID RX RWB
      add_vec(6'h00, 6'h20, 0, 4, pth(ST_IF,ST_ID,ST_RX,ST_RWB,0), 0, b_if);
      add_vec(6'h00, 6'h20, 0, 4, pth(ST_IF,ST_ID,ST_RX,ST_RWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b010,2'b00,0));
      add_vec(6'h00, 6'h22, 0, 4, pth(ST_IF,ST_ID,ST_RX,ST_RWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b00,0));
      add_vec(6'h00, 6'h24, 0, 4, pth(ST_IF,ST_ID,ST_RX,ST_RWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b000,2'b00,0));
      add_vec(6'h00, 6'h25, 0, 4, pth(ST_IF,ST_ID,ST_RX,ST_RWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b001,2'b00,0));
      add_vec(6'h00, 6'h27, 0, 4, pth(ST_IF,ST_ID,ST_RX,ST_RWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b100,2'b00,0));
      add_vec(6'h00, 6'h2A, 0, 4, pth(ST_IF,ST_ID,ST_RX,ST_RWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b111,2'b00,0));
      add_vec(6'h00, 6'h25, 0, 4, pth(ST_IF,ST_ID,ST_RX,ST_RWB,0), 3, eb(0,0,0,0,0,2'b01,2'b00,1,0,2'b00,0,3'b000,2'b00,0));
      // lw / sw
      add_vec(6'h23, 6'h00, 0, 5, pth(ST_IF,ST_ID,ST_MA,ST_MR,ST_MWB), 4, eb(0,0,0,0,0,2'b00,2'b01,1,0,2'b00,0,3'b000,2'b00,0));
      add_vec(6'h23, 6'h00, 0, 5, pth(ST_IF,ST_ID,ST_MA,ST_MR,ST_MWB), 3, eb(0,1,1,0,0,2'b00,2'b00,0,0,2'b00,0,3'b000,2'b00,0));
      add_vec(6'h2B, 6'h00, 0, 4, pth(ST_IF,ST_ID,ST_MA,ST_MW,0), 3, eb(0,1,0,1,0,2'b00,2'b00,0,0,2'b00,0,3'b000,2'b00,0));
      add_vec(6'h2B, 6'h00, 0, 4, pth(ST_IF,ST_ID,ST_MA,ST_MW,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,0,3'b010,2'b00,0));
      // immediates: IF ID IX IWB
      add_vec(6'h08, 6'h00, 0, 4, pth(ST_IF,ST_ID,ST_IX,ST_IWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,0,3'b010,2'b00,0));
      add_vec(6'h0C, 6'h00, 0, 4, pth(ST_IF,ST_ID,ST_IX,ST_IWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,1,3'b000,2'b00,0));
      add_vec(6'h0D, 6'h00, 0, 4, pth(ST_IF,ST_ID,ST_IX,ST_IWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,1,3'b001,2'b00,0));
      add_vec(6'h0A, 6'h00, 0, 4, pth(ST_IF,ST_ID,ST_IX,ST_IWB,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,0,3'b111,2'b00,0));
      add_vec(6'h0A, 6'h00, 0, 4, pth(ST_IF,ST_ID,ST_IX,ST_IWB,0), 3, eb(0,0,0,0,0,2'b00,2'b00,1,0,2'b00,0,3'b000,2'b00,0));
      // branches: pc_write follows zero (beq) / ~zero (bne)
      add_vec(6'h04, 6'h00, 0, 3, pth(ST_IF,ST_ID,ST_BR,0,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b01,0));
      add_vec(6'h04, 6'h00, 1, 3, pth(ST_IF,ST_ID,ST_BR,0,0), 2, eb(1,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b01,0));
      add_vec(6'h05, 6'h00, 0, 3, pth(ST_IF,ST_ID,ST_BR,0,0), 2, eb(1,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b01,0));
      add_vec(6'h05, 6'h00, 1, 3, pth(ST_IF,ST_ID,ST_BR,0,0), 2, eb(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b01,0));
      // jumps, lui
      add_vec(6'h02, 6'h00, 0, 3, pth(ST_IF,ST_ID,ST_J,0,0), 1, b_id);
      add_vec(6'h02, 6'h00, 0, 3, pth(ST_IF,ST_ID,ST_J,0,0), 2, eb(1,0,0,0,0,2'b00,2'b00,0,0,2'b00,0,3'b000,2'b10,0));
      add_vec(6'h03, 6'h00, 0, 3, pth(ST_IF,ST_ID,ST_JAL,0,0), 2, eb(1,0,0,0,0,2'b10,2'b10,1,0,2'b00,0,3'b000,2'b10,0));
      add_vec(6'h00, 6'h08, 0, 3, pth(ST_IF,ST_ID,ST_JR,0,0), 2, eb(1,0,0,0,0,2'b00,2'b00,0,0,2'b00,0,3'b000,2'b11,0));
      add_vec(6'h0F, 6'h00, 0, 3, pth(ST_IF,ST_ID,ST_LUI,0,0), 2, eb(0,0,0,0,0,2'b00,2'b11,1,0,2'b00,0,3'b000,2'b00,0));
      // illegal opcode and illegal R-type funct
      add_vec(6'h3F, 6'h00, 0, 2, pth(ST_IF,ST_ID,0,0,0), 1, eb(0,0,0,0,0,2'b00,2'b00,0,0,2'b11,0,3'b010,2'b00,1));
      add_vec(6'h00, 6'h3F, 0, 2, pth(ST_IF,ST_ID,0,0,0), 1, eb(0,0,0,0,0,2'b00,2'b00,0,0,2'b11,0,3'b010,2'b00,1));

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 0, {27'd0, state}, {27'd0, ST_RST});
      check("reset_outputs", 0, {11'd0, obs}, {11'd0, b_zero});
      @(negedge clk) rst_n = 1'b1;
      step();
      check("reset_release_if", 0, {27'd0, state}, {27'd0, ST_IF});
      check("if_outputs", 0, {11'd0, obs}, {11'd0, b_if});

      for (int v = 0; v < nvec; v++) run_vec(v);

      // illegal pulse lasts one cycle and no write strobe follows
      opcode = 6'h3F;
      funct  = 6'h00;
      step();
      check("illegal_in_id", 100, {31'd0, illegal}, 32'd1);
      step();
      check("illegal_next_if", 100, {27'd0, state}, {27'd0, ST_IF});
      check("illegal_cleared", 100, {29'd0, illegal, mem_write, reg_write}, 32'd0);

      // opcode is only sampled in ID: changing it in MA must not divert lw
      opcode = 6'h23;
      step();
      step();
      check("ma_reached", 101, {27'd0, state}, {27'd0, ST_MA});
      opcode = 6'h2B;
      step();
      check("ir_sampled_in_id", 101, {27'd0, state}, {27'd0, ST_MR});
      step();
      check("lw_wb_after_change", 101, {27'd0, state}, {27'd0, ST_MWB});
      step();
      check("back_if_101", 101, {27'd0, state}, {27'd0, ST_IF});

      // async reset mid-MR clears state and outputs without a clock edge
      opcode = 6'h23;
      step();
      step();
      step();
      check("mr_reached", 102, {27'd0, state}, {27'd0, ST_MR});
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_state", 102, {27'd0, state}, {27'd0, ST_RST});
      check("async_reset_outputs", 102, {11'd0, obs}, {11'd0, b_zero});
      step();
      check("reset_hold_state", 102, {27'd0, state}, {27'd0, ST_RST});
      @(negedge clk) rst_n = 1'b1;
      step();
      check("release_to_if", 102, {27'd0, state}, {27'd0, ST_IF});

`ifdef MCCTRL_MEM_WAIT_EN
      // fetch stalls for three cycles, completes on the fourth
      opcode    = 6'h02;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("wait_hold_state", 200 + i, {27'd0, state}, {27'd0, ST_IF});
         check("wait_hold_strobes", 200 + i, {29'd0, mem_read, ir_write, pc_write}, 32'd4);
         step();
      end
      mem_ready = 1'b1;
      #1;
      check("wait_done_strobes", 203, {29'd0, mem_read, ir_write, pc_write}, 32'd7);
      step();
      check("wait_done_id", 203, {27'd0, state}, {27'd0, ST_ID});
      step();
      step();
      check("wait_back_if", 204, {27'd0, state}, {27'd0, ST_IF});
      // no mem_ready at all: timeout after 16 cycles
      mem_ready = 1'b0;
      repeat (15) step();
      check("no_bus_err_early", 205, {31'd0, bus_err}, 32'd0);
      step();
      check("bus_err_pulse", 205, {31'd0, bus_err}, 32'd1);
      check("bus_err_state_if", 205, {27'd0, state}, {27'd0, ST_IF});
      check("bus_err_no_update", 205, {29'd0, pc_write, ir_write, reg_write}, 32'd0);
      step();
      check("bus_err_one_cycle", 205, {31'd0, bus_err}, 32'd0);
      mem_ready = 1'b1;
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
